// File: rtl/fx2_wr_ctrl_if.sv
// Stream, marker and FX2 slave-FIFO write-side signals of fx2_wr_ctrl.
// slave = the write controller, master = the surrounding capture/FX2 logic.
interface fx2_wr_ctrl_if;
  logic [15:0] s_data_i;
  logic        s_valid_i;
  logic        s_ready_o;
  logic [15:0] m_data_i;
  logic        m_req_i;
  logic        m_ack_o;
  logic        full_n_i;
  logic        slwr_o;
  logic        pktend_o;
  logic [15:0] fd_o;

  modport slave (
    input  s_data_i, s_valid_i, m_data_i, m_req_i, full_n_i,
    output s_ready_o, m_ack_o, slwr_o, pktend_o, fd_o
  );

  modport master (
    output s_data_i, s_valid_i, m_data_i, m_req_i, full_n_i,
    input  s_ready_o, m_ack_o, slwr_o, pktend_o, fd_o
  );
endinterface

// File: rtl/fx2_wr_ctrl.sv
// FX2 slave-FIFO write controller: merges stream and marker words into FX2
// packets, committing short packets on flush, idle timeout or enable drop.
module fx2_wr_ctrl #(
  parameter int unsigned PKT_WORDS    = 256,
  parameter int unsigned IDLE_TIMEOUT = 1024
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic               flush_i,
  fx2_wr_ctrl_if.slave       bus,
  output logic [15:0]        pkt_count_o,
  output logic               busy_o
);

  localparam int unsigned CW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(PKT_WORDS - 1);
  localparam logic [15:0]   IDLE_HIT  = 16'(IDLE_TIMEOUT - 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] word_cnt, word_cnt_nx;
  logic [15:0]   idle_cnt, idle_cnt_nx;
  logic [15:0]   pkt_cnt_nx;
  logic          marker_last, marker_last_nx;
  logic          enable_q;

  logic          wr;
  logic          sel_stream;
  logic          pktend;
  logic          pending;
  logic          at_last;
  logic          en_fall;
  logic          flush_req;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= RUN;
      word_cnt    <= '0;
      idle_cnt    <= '0;
      pkt_count_o <= '0;
      marker_last <= 1'b0;
      enable_q    <= 1'b0;
    end else begin
      state       <= state_nx;
      word_cnt    <= word_cnt_nx;
      idle_cnt    <= idle_cnt_nx;
      pkt_count_o <= pkt_cnt_nx;
      marker_last <= marker_last_nx;
      enable_q    <= enable_i;
    end
  end

  always_comb begin
    state_nx       = state;
    word_cnt_nx    = word_cnt;
    idle_cnt_nx    = idle_cnt;
    pkt_cnt_nx     = pkt_count_o;
    marker_last_nx = marker_last;
    wr             = 1'b0;
    sel_stream     = 1'b0;
    pktend         = 1'b0;
    flush_req      = 1'b0;
    pending        = (word_cnt != '0);
    at_last        = (word_cnt == LAST_WORD);
    en_fall        = enable_q & ~enable_i;

    unique case (state)
      RUN: begin
        if (!reset_i && enable_i && bus.full_n_i && (bus.m_req_i || bus.s_valid_i)) begin
          wr = 1'b1;
          // Marker has priority, but a marker never follows a marker while stream data waits.
          sel_stream = bus.s_valid_i && (!bus.m_req_i || marker_last);
        end
        flush_req = pending && (flush_i || (idle_cnt == IDLE_HIT) || en_fall);

        if (wr) begin
          marker_last_nx = ~sel_stream;
          if (at_last) begin
            word_cnt_nx = '0;
            pkt_cnt_nx  = pkt_count_o + 16'd1;
          end else begin
            word_cnt_nx = word_cnt + 1'b1;
          end
        end

        if (wr || !pending)
          idle_cnt_nx = '0;
        else if (idle_cnt != '1)
          idle_cnt_nx = idle_cnt + 16'd1;

        // A wrapping write already committed the packet, so there is nothing left to flush.
        if (flush_req && !(wr && at_last))
          state_nx = FLUSH;
      end

      FLUSH: begin
        if (!reset_i && bus.full_n_i) begin
          pktend      = 1'b1;
          word_cnt_nx = '0;
          idle_cnt_nx = '0;
          pkt_cnt_nx  = pkt_count_o + 16'd1;
          state_nx    = RUN;
        end
      end
    endcase
  end

  assign bus.slwr_o    = wr;
  assign bus.pktend_o  = pktend;
  assign bus.s_ready_o = wr & sel_stream;
  assign bus.m_ack_o   = wr & ~sel_stream;
  assign bus.fd_o      = !wr ? '0 : (sel_stream ? bus.s_data_i : bus.m_data_i);
  assign busy_o        = pending || (state == FLUSH);

  a_strobe_excl: assert property (@(posedge clk_i) disable iff (reset_i)
    !(bus.slwr_o && bus.pktend_o));
  a_strobe_full: assert property (@(posedge clk_i) disable iff (reset_i)
    (bus.slwr_o || bus.pktend_o) |-> bus.full_n_i);
  a_ack_excl: assert property (@(posedge clk_i) disable iff (reset_i)
    !(bus.s_ready_o && bus.m_ack_o));

endmodule

// File: tb/tb_fx2_wr_ctrl.sv
// Directed bench for fx2_wr_ctrl with PKT_WORDS=4, IDLE_TIMEOUT=8.
module tb_fx2_wr_ctrl;
  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        enable_i;
  logic        flush_i;
  logic [15:0] pkt_count_o;
  logic        busy_o;

  fx2_wr_ctrl_if bus();

  fx2_wr_ctrl #(.PKT_WORDS(4), .IDLE_TIMEOUT(8)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .enable_i    (enable_i),
    .flush_i     (flush_i),
    .bus         (bus),
    .pkt_count_o (pkt_count_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned idle_seen;
    logic        got_pe;
    logic        exp_m;

    reset_i = 1'b1; enable_i = 1'b1; flush_i = 1'b0;
    bus.s_valid_i = 1'b1; bus.m_req_i = 1'b1; bus.full_n_i = 1'b1;
    bus.s_data_i = 16'h1234; bus.m_data_i = 16'hBEEF;
    repeat (2) next_cycle();
    #2;
    check("rst slwr",    32'(bus.slwr_o),    32'd0);
    check("rst pktend",  32'(bus.pktend_o),  32'd0);
    check("rst s_ready", 32'(bus.s_ready_o), 32'd0);
    check("rst m_ack",   32'(bus.m_ack_o),   32'd0);
    check("rst fd",      32'(bus.fd_o),      32'd0);
    check("rst pkt",     32'(pkt_count_o),   32'd0);
    check("rst busy",    32'(busy_o),        32'd0);
    next_cycle();

    // Eight stream words = two full packets, auto-committed
    reset_i = 1'b0; bus.m_req_i = 1'b0; bus.s_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.s_data_i = 16'h1000 + 16'(i);
      #2;
      check("t1 slwr",    32'(bus.slwr_o),    32'd1);
      check("t1 s_ready", 32'(bus.s_ready_o), 32'd1);
      check("t1 fd",      32'(bus.fd_o),      32'h1000 + 32'(i));
      check("t1 pktend",  32'(bus.pktend_o),  32'd0);
      next_cycle();
    end
    bus.s_valid_i = 1'b0;
    #2;
    check("t1 pkt",  32'(pkt_count_o), 32'd2);
    check("t1 busy", 32'(busy_o),      32'd0);
    check("t1 idle", 32'(bus.slwr_o),  32'd0);
    next_cycle();

    // Marker/stream alternation, marker first
    bus.m_req_i = 1'b1; bus.s_valid_i = 1'b1; bus.m_data_i = 16'hA5A5;
    for (int i = 0; i < 6; i++) begin
      bus.s_data_i = 16'h2000 + 16'(i);
      exp_m = ((i % 2) == 0);
      #2;
      check("t2 m_ack",   32'(bus.m_ack_o),   32'(exp_m));
      check("t2 s_ready", 32'(bus.s_ready_o), 32'(!exp_m));
      check("t2 fd",      32'(bus.fd_o),      exp_m ? 32'hA5A5 : 32'h2000 + 32'(i));
      next_cycle();
    end

    // word_cnt=2: flush while FX2 full for 5 cycles, flush_i kept high meanwhile
    bus.m_req_i = 1'b0; bus.s_valid_i = 1'b0; bus.full_n_i = 1'b0; flush_i = 1'b1;
    #2;
    check("t3 pkt pre",  32'(pkt_count_o), 32'd3);
    check("t3 busy pre", 32'(busy_o),      32'd1);
    next_cycle();
    bus.s_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      check("t3 stall pktend",  32'(bus.pktend_o),  32'd0);
      check("t3 stall slwr",    32'(bus.slwr_o),    32'd0);
      check("t3 stall s_ready", 32'(bus.s_ready_o), 32'd0);
      next_cycle();
    end
    bus.full_n_i = 1'b1; flush_i = 1'b0;
    #2;
    check("t3 pktend",  32'(bus.pktend_o),  32'd1);
    check("t3 slwr",    32'(bus.slwr_o),    32'd0);
    check("t3 s_ready", 32'(bus.s_ready_o), 32'd0);
    next_cycle();
    bus.s_valid_i = 1'b0;
    #2;
    check("t3 pkt post",  32'(pkt_count_o),  32'd4);
    check("t3 busy post", 32'(busy_o),       32'd0);
    check("t3 pe once",   32'(bus.pktend_o), 32'd0);
    next_cycle();

    // Flush with nothing pending
    flush_i = 1'b1;
    #2;
    check("t4 pktend0", 32'(bus.pktend_o), 32'd0);
    next_cycle();
    flush_i = 1'b0;
    #2;
    check("t4 pktend1", 32'(bus.pktend_o), 32'd0);
    check("t4 busy",    32'(busy_o),       32'd0);
    check("t4 pkt",     32'(pkt_count_o),  32'd4);
    next_cycle();

    // Idle timeout: 3 words then 8 idle cycles before pktend
    bus.s_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("t5 slwr", 32'(bus.slwr_o), 32'd1);
      next_cycle();
    end
    bus.s_valid_i = 1'b0;
    idle_seen = 0; got_pe = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #2;
      if (bus.pktend_o) begin
        got_pe = 1'b1;
        break;
      end
      idle_seen++;
      next_cycle();
    end
    check("t5 pktend seen",  32'(got_pe),    32'd1);
    check("t5 idle cycles",  32'(idle_seen), 32'd8);
    next_cycle();
    #2;
    check("t5 pe pulse", 32'(bus.pktend_o), 32'd0);
    check("t5 pkt",      32'(pkt_count_o),  32'd5);
    check("t5 busy",     32'(busy_o),       32'd0);
    next_cycle();

    // Enable falling with 2 words pending
    bus.s_valid_i = 1'b1;
    repeat (2) next_cycle();
    enable_i = 1'b0;
    #2;
    check("t6 slwr off", 32'(bus.slwr_o),   32'd0);
    check("t6 no pe",    32'(bus.pktend_o), 32'd0);
    next_cycle();
    #2;
    check("t6 pktend", 32'(bus.pktend_o), 32'd1);
    next_cycle();
    bus.s_valid_i = 1'b0; enable_i = 1'b1;
    #2;
    check("t6 pkt",  32'(pkt_count_o), 32'd6);
    check("t6 busy", 32'(busy_o),      32'd0);
    next_cycle();

    // Flush coinciding with a wrapping write: no FLUSH
    bus.s_valid_i = 1'b1;
    repeat (3) next_cycle();
    flush_i = 1'b1;
    #2;
    check("t7 slwr", 32'(bus.slwr_o), 32'd1);
    next_cycle();
    flush_i = 1'b0; bus.s_valid_i = 1'b0;
    #2;
    check("t7 pktend", 32'(bus.pktend_o), 32'd0);
    check("t7 busy",   32'(busy_o),       32'd0);
    check("t7 pkt",    32'(pkt_count_o),  32'd7);
    next_cycle();

    // Flush coinciding with a non-wrapping write: FLUSH next cycle
    bus.s_valid_i = 1'b1;
    next_cycle();
    flush_i = 1'b1;
    #2;
    check("t8 slwr", 32'(bus.slwr_o), 32'd1);
    next_cycle();
    flush_i = 1'b0;
    #2;
    check("t8 pktend",  32'(bus.pktend_o),  32'd1);
    check("t8 slwr",    32'(bus.slwr_o),    32'd0);
    check("t8 s_ready", 32'(bus.s_ready_o), 32'd0);
    next_cycle();
    bus.s_valid_i = 1'b0;
    #2;
    check("t8 pkt",  32'(pkt_count_o), 32'd8);
    check("t8 busy", 32'(busy_o),      32'd0);
    next_cycle();

    // Asynchronous reset mid-packet
    bus.s_valid_i = 1'b1;
    repeat (2) next_cycle();
    bus.m_req_i = 1'b1;
    #2;
    check("t9 pre slwr", 32'(bus.slwr_o), 32'd1);
    #1 reset_i = 1'b1;
    #1;
    check("t9 slwr",    32'(bus.slwr_o),    32'd0);
    check("t9 pktend",  32'(bus.pktend_o),  32'd0);
    check("t9 s_ready", 32'(bus.s_ready_o), 32'd0);
    check("t9 m_ack",   32'(bus.m_ack_o),   32'd0);
    check("t9 fd",      32'(bus.fd_o),      32'd0);
    check("t9 busy",    32'(busy_o),        32'd0);
    check("t9 pkt",     32'(pkt_count_o),   32'd0);
    next_cycle();
    reset_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      check("t9 slwr post", 32'(bus.slwr_o),  32'd1);
      check("t9 m_ack alt", 32'(bus.m_ack_o), 32'((i % 2) == 0));
      next_cycle();
    end
    bus.m_req_i = 1'b0; bus.s_valid_i = 1'b0;
    #2;
    check("t9 pkt post",  32'(pkt_count_o), 32'd1);
    check("t9 busy post", 32'(busy_o),      32'd0);
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fx2_wr_ctrl.md
FX2_WR_CTRL -- requirements
Module: fx2_wr_ctrl

Interface
REQ-001: Parameter PKT_WORDS, default 256, 16-bit words per full FX2 packet (power of two, 2..1024).
REQ-002: Parameter IDLE_TIMEOUT, default 1024, idle cycles with a partial packet pending before an automatic short-packet commit (2..65535).
REQ-003: clk_i  input  1  interface clock (ifclk domain); all logic on rising edge.
REQ-004: reset_i  input  1  reset; asynchronous, active-high.
REQ-005: enable_i  input  1  write enable; low blocks all word writes.
REQ-006: flush_i  input  1  single-cycle request to commit the pending partial packet.
REQ-007: s_data_i  input  16  stream word from the capture FIFO (first-word-fall-through).
REQ-008: s_valid_i  input  1  s_data_i valid.
REQ-009: s_ready_o  output  1  stream word consumed this cycle.
REQ-010: m_data_i  input  16  marker/status word.
REQ-011: m_req_i  input  1  marker word pending; held until acknowledged.
REQ-012: m_ack_o  output  1  marker word written this cycle.
REQ-013: full_n_i  input  1  FX2 FIFO can accept a write or pktend (high = ready).
REQ-014: slwr_o  output  1  FX2 write strobe, active-high.
REQ-015: pktend_o  output  1  FX2 packet-end strobe, active-high.
REQ-016: fd_o  output  16  FX2 data bus.
REQ-017: pkt_count_o  output  16  committed packets (full plus short), wrapping.
REQ-018: busy_o  output  1  high while a partial packet is pending or state is FLUSH.

Function
REQ-019: States RUN and FLUSH; internal word_cnt (0..PKT_WORDS-1), idle_cnt (16 bits), marker-last flag.
REQ-020: In RUN, a write occurs when enable_i=1, full_n_i=1 and (m_req_i=1 or s_valid_i=1); slwr_o, s_ready_o, m_ack_o and fd_o are combinational from current inputs and state (zero latency).
REQ-021: Arbitration: marker wins unless the previous write was a marker and s_valid_i=1, in which case stream wins; no source starves.
REQ-022: At most one of s_ready_o, m_ack_o is high per cycle; whichever is high equals slwr_o; fd_o carries the selected word, else 16'h0000.
REQ-023: Each write increments word_cnt; at PKT_WORDS-1 plus a write, word_cnt wraps to 0 and pkt_count_o increments (FX2 auto-commit; no pktend).
REQ-024: idle_cnt clears on every write or when word_cnt=0; otherwise it increments each cycle, saturating.
REQ-025: RUN->FLUSH when word_cnt!=0 and any of: flush_i=1, idle_cnt=IDLE_TIMEOUT-1, or enable_i 1->0 transition.
REQ-026: flush_i or enable_i falling with word_cnt=0 is ignored (no zero-length packet).
REQ-027: If a RUN->FLUSH condition and a write coincide, the write completes that cycle and FLUSH is entered next cycle; if that write wrapped word_cnt to 0, FLUSH is not entered.
REQ-028: In FLUSH no writes (slwr_o, s_ready_o, m_ack_o = 0); pktend_o = full_n_i; on the pktend_o cycle word_cnt<=0, idle_cnt<=0, pkt_count_o increments, next state RUN.
REQ-029: slwr_o and pktend_o are never high together; both require full_n_i=1.
REQ-030: flush_i asserted during FLUSH has no additional effect.
REQ-031: pkt_count_o wraps 16'hFFFF->16'h0000.

Reset
REQ-032: reset_i=1 forces state RUN, word_cnt=0, idle_cnt=0, marker-last=0, pkt_count_o=0, busy_o=0 immediately without a clock edge.
REQ-033: During reset slwr_o, pktend_o, s_ready_o, m_ack_o = 0 and fd_o = 16'h0000 regardless of other inputs; reset mid-packet discards the partial count without issuing pktend_o.

Verification
REQ-034: PKT_WORDS=4; enable_i=1, full_n_i=1, s_valid_i=1 for 8 cycles -> 8 slwr_o pulses, no pktend_o, pkt_count_o=2.
REQ-035: m_req_i and s_valid_i held high -> strict alternation of m_ack_o/s_ready_o starting with m_ack_o; fd_o equals selected word each cycle.
REQ-036: IDLE_TIMEOUT=8; 3 words written, then s_valid_i=0 -> pktend_o single pulse 8 cycles after last write, pkt_count_o=1, busy_o falls.
REQ-037: flush_i with word_cnt=2 while full_n_i=0 for 5 cycles -> no strobes during stall, pktend_o in first cycle full_n_i=1; flush_i with word_cnt=0 -> no pktend_o.
REQ-038: reset_i asserted asynchronously mid-packet -> outputs zero before next clock edge; after release, 4 full words give pkt_count_o=1 (PKT_WORDS=4), proving word_cnt restarted at 0.
